// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between instruction fetch (port 0)
// and data load (port 1), with programmable wait cycles and a one-entry response buffer per port.
module rom_read_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp0_err,
   input  logic              rsp0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              rsp1_err,
   input  logic              rsp1_ready,
   output logic [ADDR_W-1:0] rom_address,
   output logic              rom_read_en,
   output logic              rom_ce,
   input  logic [DATA_W-1:0] rom_data
);

   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WORD_W = ADDR_W - 2;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0]              state, state_nxt;
   logic                    last_grant, last_grant_nxt;
   logic [CNT_W-1:0]        cnt, cnt_nxt;
   logic [WORD_W-1:0]       word_q, word_nxt;
   logic                    port_q, port_nxt;
   logic                    err_q, err_nxt;
   logic [1:0]              rsp_v, rsp_v_nxt;
   logic [1:0]              rsp_e, rsp_e_nxt;
   logic [1:0][DATA_W-1:0]  rsp_d, rsp_d_nxt;

   logic [1:0]              rsp_rdy;
   logic [1:0]              elig;
   logic [1:0]              gnt;
   logic                    sel;
   logic [ADDR_W-1:0]       sel_addr;

   assign rsp_rdy = {rsp1_ready, rsp0_ready};
   assign elig    = {req1_valid && !rsp_v[1], req0_valid && !rsp_v[0]};

   // Next-state, grant and response-buffer logic
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      cnt_nxt        = cnt;
      word_nxt       = word_q;
      port_nxt       = port_q;
      err_nxt        = err_q;
      rsp_v_nxt      = rsp_v;
      rsp_e_nxt      = rsp_e;
      rsp_d_nxt      = rsp_d;
      gnt            = 2'b00;
      sel            = 1'b0;
      sel_addr       = req0_addr;

      for (int i = 0; i < 2; i++) begin
         if (rsp_v[i] && rsp_rdy[i]) rsp_v_nxt[i] = 1'b0;
      end

      case (state)
         IDLE: begin
            if (elig == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
            else               gnt = elig;
            if (gnt != 2'b00) begin
               sel            = gnt[1];
               sel_addr       = sel ? req1_addr : req0_addr;
               word_nxt       = sel_addr[ADDR_W-1:2];
               port_nxt       = sel;
               err_nxt        = (sel_addr[1:0] != 2'b00);
               cnt_nxt        = CNT_W'(WAIT_CYCLES);
               last_grant_nxt = sel;
               state_nxt      = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt != '0) begin
               cnt_nxt = CNT_W'(cnt - 1'b1);
            end else begin
               rsp_d_nxt[port_q] = rom_data;
               rsp_v_nxt[port_q] = 1'b1;
               rsp_e_nxt[port_q] = err_q;
               state_nxt         = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         word_q     <= '0;
         port_q     <= 1'b0;
         err_q      <= 1'b0;
         rsp_v      <= '0;
         rsp_e      <= '0;
         rsp_d      <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         cnt        <= cnt_nxt;
         word_q     <= word_nxt;
         port_q     <= port_nxt;
         err_q      <= err_nxt;
         rsp_v      <= rsp_v_nxt;
         rsp_e      <= rsp_e_nxt;
         rsp_d      <= rsp_d_nxt;
      end
   end

   // Ready is a same-cycle grant pulse; ROM pins are decoded from the state register
   assign req0_ready  = gnt[0] && !rst;
   assign req1_ready  = gnt[1] && !rst;
   assign rom_ce      = (state == ACCESS);
   assign rom_read_en = (state == ACCESS);
   assign rom_address = (state == ACCESS) ? {2'b00, word_q} : '0;

   assign rsp0_valid = rsp_v[0];
   assign rsp0_data  = rsp_d[0];
   assign rsp0_err   = rsp_e[0];
   assign rsp1_valid = rsp_v[1];
   assign rsp1_data  = rsp_d[1];
   assign rsp1_err   = rsp_e[1];

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: two instances (WAIT_CYCLES 0 and 3) driven by directed and
// random traffic, checked every cycle against a transaction-level reference model.
module tb_rom_read_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_valid   [2][2];
   logic [31:0] req_addr    [2][2];
   logic        req_ready   [2][2];
   logic        rsp_valid   [2][2];
   logic [31:0] rsp_data    [2][2];
   logic        rsp_err     [2][2];
   logic        rsp_ready   [2][2];
   logic [31:0] rom_address [2];
   logic        rom_read_en [2];
   logic        rom_ce      [2];
   logic [31:0] rom_data    [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'd4) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   assign rom_data[0] = rom_word(rom_address[0]);
   assign rom_data[1] = rom_word(rom_address[1]);

   rom_read_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .req0_valid(req_valid[0][0]), .req0_addr(req_addr[0][0]), .req0_ready(req_ready[0][0]),
      .rsp0_valid(rsp_valid[0][0]), .rsp0_data(rsp_data[0][0]), .rsp0_err(rsp_err[0][0]),
      .rsp0_ready(rsp_ready[0][0]),
      .req1_valid(req_valid[0][1]), .req1_addr(req_addr[0][1]), .req1_ready(req_ready[0][1]),
      .rsp1_valid(rsp_valid[0][1]), .rsp1_data(rsp_data[0][1]), .rsp1_err(rsp_err[0][1]),
      .rsp1_ready(rsp_ready[0][1]),
      .rom_address(rom_address[0]), .rom_read_en(rom_read_en[0]), .rom_ce(rom_ce[0]),
      .rom_data(rom_data[0])
   );

   rom_read_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) u_dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(req_valid[1][0]), .req0_addr(req_addr[1][0]), .req0_ready(req_ready[1][0]),
      .rsp0_valid(rsp_valid[1][0]), .rsp0_data(rsp_data[1][0]), .rsp0_err(rsp_err[1][0]),
      .rsp0_ready(rsp_ready[1][0]),
      .req1_valid(req_valid[1][1]), .req1_addr(req_addr[1][1]), .req1_ready(req_ready[1][1]),
      .rsp1_valid(rsp_valid[1][1]), .rsp1_data(rsp_data[1][1]), .rsp1_err(rsp_err[1][1]),
      .rsp1_ready(rsp_ready[1][1]),
      .rom_address(rom_address[1]), .rom_read_en(rom_read_en[1]), .rom_ce(rom_ce[1]),
      .rom_data(rom_data[1])
   );

   // Reference model: one outstanding transaction per instance, finishing at a known cycle
   bit          m_busy [2];
   int          m_port [2];
   logic [31:0] m_addr [2];
   bit          m_err  [2];
   int          m_done [2];
   int          m_last [2];
   bit          m_rv   [2][2];
   logic [31:0] m_rd   [2][2];
   bit          m_re   [2][2];
   bit          m_gnt  [2][2];

   logic        snap_ready [2][2];
   logic        snap_rv    [2][2];
   logic [31:0] snap_rd    [2][2];
   logic        snap_re    [2][2];
   logic [31:0] snap_addr  [2];

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_port[k] = 0; m_addr[k] = '0; m_err[k] = 0;
         m_done[k] = 0; m_last[k] = 1;
         for (int i = 0; i < 2; i++) begin
            m_rv[k][i] = 0; m_rd[k][i] = '0; m_re[k][i] = 0; m_gnt[k][i] = 0;
         end
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = 32'($urandom_range(63)) << 2;
      if ($urandom_range(7) == 0) a[1:0] = 2'($urandom_range(3, 1));
      return a;
   endfunction

   // Called just after a falling edge with inputs applied; checks, advances model, waits a cycle
   task automatic run_cycle();
      int  g;
      bit  e0, e1;
      #1;
      for (int k = 0; k < 2; k++) begin
         g = -1;
         if (!m_busy[k]) begin
            e0 = req_valid[k][0] && !m_rv[k][0];
            e1 = req_valid[k][1] && !m_rv[k][1];
            if (e0 && e1)  g = (m_last[k] == 0) ? 1 : 0;
            else if (e0)   g = 0;
            else if (e1)   g = 1;
         end
         check($sformatf("k%0d rom_ce", k), 32'(rom_ce[k]), 32'(m_busy[k]));
         check($sformatf("k%0d rom_read_en", k), 32'(rom_read_en[k]), 32'(m_busy[k]));
         check($sformatf("k%0d rom_address", k), rom_address[k], m_busy[k] ? (m_addr[k] >> 2) : 32'd0);
         snap_addr[k] = rom_address[k];
         for (int i = 0; i < 2; i++) begin
            m_gnt[k][i] = (g == i);
            check($sformatf("k%0d req%0d_ready", k, i), 32'(req_ready[k][i]), 32'(m_gnt[k][i]));
            check($sformatf("k%0d rsp%0d_valid", k, i), 32'(rsp_valid[k][i]), 32'(m_rv[k][i]));
            check($sformatf("k%0d rsp%0d_data", k, i), rsp_data[k][i], m_rd[k][i]);
            check($sformatf("k%0d rsp%0d_err", k, i), 32'(rsp_err[k][i]), 32'(m_re[k][i]));
            snap_ready[k][i] = req_ready[k][i];
            snap_rv[k][i]    = rsp_valid[k][i];
            snap_rd[k][i]    = rsp_data[k][i];
            snap_re[k][i]    = rsp_err[k][i];
         end
         for (int i = 0; i < 2; i++)
            if (m_rv[k][i] && rsp_ready[k][i]) m_rv[k][i] = 0;
         if (m_busy[k] && cyc == m_done[k]) begin
            m_rd[k][m_port[k]] = rom_word(m_addr[k] >> 2);
            m_rv[k][m_port[k]] = 1;
            m_re[k][m_port[k]] = m_err[k];
            m_busy[k] = 0;
         end else if (g >= 0) begin
            m_busy[k] = 1;
            m_port[k] = g;
            m_addr[k] = req_addr[k][g];
            m_err[k]  = (req_addr[k][g][1:0] != 2'b00);
            m_last[k] = g;
            m_done[k] = cyc + 1 + wait_of(k);
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   // mode 0: random legal traffic, 1: both ports always requesting, 2: as 1 with port 0 stalled
   task automatic gen_inputs(input int mode);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            case (mode)
               0: begin
                  if (req_valid[k][i] && !m_gnt[k][i]) begin
                     if ($urandom_range(15) == 0) req_valid[k][i] = 1'b0;
                  end else begin
                     req_valid[k][i] = ($urandom_range(1) == 1);
                     req_addr[k][i]  = rand_addr();
                  end
                  rsp_ready[k][i] = ($urandom_range(3) != 0);
               end
               1: begin
                  req_valid[k][i] = 1'b1;
                  req_addr[k][i]  = 32'(i * 4);
                  rsp_ready[k][i] = 1'b1;
               end
               default: begin
                  req_valid[k][i] = 1'b1;
                  req_addr[k][i]  = 32'(i * 4);
                  rsp_ready[k][i] = (i == 1);
               end
            endcase
         end
      end
   endtask

   task automatic idle_inputs();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 2; i++) begin
            req_valid[k][i] = 1'b0;
            req_addr[k][i]  = '0;
            rsp_ready[k][i] = 1'b1;
         end
   endtask

   // Single aligned or misaligned read on instance 0, port 0, with fixed expectations
   task automatic single_read(input logic [31:0] addr, input logic exp_err);
      idle_inputs();
      req_valid[0][0] = 1'b1;
      req_addr[0][0]  = addr;
      run_cycle();
      check("single ready", 32'(snap_ready[0][0]), 32'd1);
      idle_inputs();
      run_cycle();
      check("single rom_address", snap_addr[0], 32'd4);
      run_cycle();
      check("single rsp_valid", 32'(snap_rv[0][0]), 32'd1);
      check("single rsp_data", snap_rd[0][0], 32'hDEADBEEF);
      check("single rsp_err", 32'(snap_re[0][0]), 32'(exp_err));
      run_cycle();
   endtask

   initial begin
      int  waited;
      rst = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst k%0d rom_ce", k), 32'(rom_ce[k]), 32'd0);
         check($sformatf("rst k%0d rom_address", k), rom_address[k], 32'd0);
         for (int i = 0; i < 2; i++) begin
            check($sformatf("rst k%0d rsp%0d_valid", k, i), 32'(rsp_valid[k][i]), 32'd0);
            check($sformatf("rst k%0d rsp%0d_data", k, i), rsp_data[k][i], 32'd0);
         end
      end
      rst = 1'b0;

      single_read(32'h0000_0010, 1'b0);
      single_read(32'h0000_0013, 1'b1);

      for (int c = 0; c < 20; c++) begin gen_inputs(1); run_cycle(); end
      for (int c = 0; c < 30; c++) begin gen_inputs(2); run_cycle(); end
      for (int c = 0; c < 12; c++) begin gen_inputs(1); run_cycle(); end
      for (int c = 0; c < 2000; c++) begin gen_inputs(0); run_cycle(); end

      // Reset in the middle of a multi-cycle access on the WAIT_CYCLES=3 instance
      waited = 0;
      while (!(m_busy[1] && cyc < m_done[1]) && waited < 200) begin
         gen_inputs(1);
         run_cycle();
         waited++;
      end
      check("reset wait for access", 32'(m_busy[1] && cyc < m_done[1]), 32'd1);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("midrst k%0d rom_ce", k), 32'(rom_ce[k]), 32'd0);
         for (int i = 0; i < 2; i++) begin
            check($sformatf("midrst k%0d rsp%0d_valid", k, i), 32'(rsp_valid[k][i]), 32'd0);
            check($sformatf("midrst k%0d req%0d_ready", k, i), 32'(req_ready[k][i]), 32'd0);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      gen_inputs(1);
      run_cycle();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("tie k%0d port0", k), 32'(snap_ready[k][0]), 32'd1);
         check($sformatf("tie k%0d port1", k), 32'(snap_ready[k][1]), 32'd0);
      end
      for (int c = 0; c < 300; c++) begin gen_inputs(0); run_cycle(); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
